// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults, width helper and typedefs for the register file scoreboard
package regfile_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int NREG_DEF = 16;
  localparam int PC_IDX_DEF = 15;
  localparam int PC_OFFSET_DEF = 8;
  function automatic int aw_of(input int n);
    return $clog2(n);
  endfunction
  typedef logic [$clog2(NREG_DEF)-1:0] reg_addr_t;
  typedef logic [DATA_W_DEF-1:0] reg_data_t;
endpackage

// File: rtl/regfile_scoreboard_if.sv
// regfile_scoreboard_if: decode/writeback side signals of the register file scoreboard
interface regfile_scoreboard_if #(
  parameter int DATA_W = regfile_pkg::DATA_W_DEF,
  parameter int NREG = regfile_pkg::NREG_DEF
);
  localparam int AW = regfile_pkg::aw_of(NREG);
  logic [AW-1:0] a1, a2, as, a3, issue_rd;
  logic [DATA_W-1:0] rd1, rd2, rds, wd3, r15;
  logic we3, issue_valid, haz1, haz2, hazs, stall;
  logic [NREG-1:0] busy;
  modport master (
    output a1, a2, as, we3, a3, wd3, r15, issue_valid, issue_rd,
    input rd1, rd2, rds, haz1, haz2, hazs, stall, busy
  );
  modport slave (
    input a1, a2, as, we3, a3, wd3, r15, issue_valid, issue_rd,
    output rd1, rd2, rds, haz1, haz2, hazs, stall, busy
  );
endinterface

// File: rtl/regfile_read_port.sv
// regfile_read_port: one combinational read port with PC substitution, write bypass and hazard mask
module regfile_read_port #(
  parameter int DATA_W = regfile_pkg::DATA_W_DEF,
  parameter int NREG = regfile_pkg::NREG_DEF,
  parameter int AW = regfile_pkg::aw_of(NREG),
  parameter int PC_IDX = regfile_pkg::PC_IDX_DEF,
  parameter int PC_OFFSET = regfile_pkg::PC_OFFSET_DEF,
  parameter int BYPASS = 1
) (
  input  logic [AW-1:0]                addr,
  input  logic [NREG-1:0][DATA_W-1:0] regs,
  input  logic [DATA_W-1:0]            r15,
  input  logic                         we3,
  input  logic [AW-1:0]                a3,
  input  logic [DATA_W-1:0]            wd3,
  input  logic [NREG-1:0]              pending,
  output logic [DATA_W-1:0]            data,
  output logic                         haz
);
  logic is_pc, fwd;
  assign is_pc = addr == AW'(PC_IDX);
  assign fwd = (BYPASS != 0) && we3 && (a3 == addr);
  assign data = is_pc ? DATA_W'(r15 + DATA_W'(PC_OFFSET)) : fwd ? wd3 : regs[addr];
  assign haz = !is_pc && pending[addr] && !fwd;
endmodule

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: ARM-style register file with three read ports and a pending-write scoreboard
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NREG = NREG_DEF,
  parameter int PC_IDX = PC_IDX_DEF,
  parameter int PC_OFFSET = PC_OFFSET_DEF,
  parameter int BYPASS = 1
) (
  input logic clk,
  input logic rst_n,
  regfile_scoreboard_if.slave bus
);
  localparam int AW = aw_of(NREG);
  logic [NREG-1:0][DATA_W-1:0] regs;
  logic [NREG-1:0] pending, pending_nxt;
  logic waw, issue_ok;
  regfile_read_port #(.DATA_W(DATA_W), .NREG(NREG), .PC_IDX(PC_IDX), .PC_OFFSET(PC_OFFSET), .BYPASS(BYPASS)) u_rp1 (
    .addr(bus.a1), .regs, .r15(bus.r15), .we3(bus.we3), .a3(bus.a3), .wd3(bus.wd3), .pending,
    .data(bus.rd1), .haz(bus.haz1)
  );
  regfile_read_port #(.DATA_W(DATA_W), .NREG(NREG), .PC_IDX(PC_IDX), .PC_OFFSET(PC_OFFSET), .BYPASS(BYPASS)) u_rp2 (
    .addr(bus.a2), .regs, .r15(bus.r15), .we3(bus.we3), .a3(bus.a3), .wd3(bus.wd3), .pending,
    .data(bus.rd2), .haz(bus.haz2)
  );
  regfile_read_port #(.DATA_W(DATA_W), .NREG(NREG), .PC_IDX(PC_IDX), .PC_OFFSET(PC_OFFSET), .BYPASS(BYPASS)) u_rps (
    .addr(bus.as), .regs, .r15(bus.r15), .we3(bus.we3), .a3(bus.a3), .wd3(bus.wd3), .pending,
    .data(bus.rds), .haz(bus.hazs)
  );
  // A writeback landing this cycle retires the old producer, so it does not block a new reservation
  assign waw = bus.issue_valid && pending[bus.issue_rd] && !(bus.we3 && bus.a3 == bus.issue_rd);
  assign bus.stall = bus.haz1 | bus.haz2 | bus.hazs | waw;
  assign issue_ok = bus.issue_valid && !bus.stall && bus.issue_rd != AW'(PC_IDX);
  assign bus.busy = pending;
  // Set is applied after clear so a same-cycle reissue keeps the register reserved
  always_comb begin
    pending_nxt = pending;
    if (bus.we3) pending_nxt[bus.a3] = 1'b0;
    if (issue_ok) pending_nxt[bus.issue_rd] = 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs <= '0;
      pending <= '0;
    end else begin
      pending <= pending_nxt;
      if (bus.we3 && bus.a3 != AW'(PC_IDX)) regs[bus.a3] <= bus.wd3;
    end
  end
endmodule
